// File: rtl/row_scan_controller.sv
// rtl/row_scan_controller.sv - cell-array row scan initiator: drives index counter strobes, assembles a 16-cell row
module row_scan_controller #(
  parameter int DWELL = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_cell_in,
  output logic        o_count_reset,
  output logic        o_scan,
  output logic [15:0] o_row_data,
  output logic        o_row_valid,
  input  logic        i_row_ready,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_dwell;
  logic [15:0] r_shadow;
  logic [15:0] r_row_data;

  logic        w_step;
  logic [15:0] w_shadow_next;

  assign w_step = (r_state == S_SAMPLE) && (r_dwell == DWELL_LAST);

  // Shadow word with the current cell merged in; on the last step this is the full row.
  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = i_cell_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_dwell    <= 8'd0;
      r_shadow   <= 16'h0000;
      r_row_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_state  <= S_SAMPLE;
          r_idx    <= 4'd0;
          r_dwell  <= 8'd0;
          r_shadow <= 16'h0000;
        end
        S_SAMPLE: begin
          if (w_step) begin
            r_shadow <= w_shadow_next;
            r_idx    <= r_idx + 4'd1;
            r_dwell  <= 8'd0;
            if (r_idx == 4'd15) begin
              r_state    <= S_DONE;
              r_row_data <= w_shadow_next;
            end
          end else begin
            r_dwell <= r_dwell + 8'd1;
          end
        end
        S_DONE: begin
          if (i_row_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_count_reset = (r_state == S_CLEAR);
  assign o_scan        = w_step;
  assign o_row_valid   = (r_state == S_DONE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_row_data    = r_row_data;

endmodule

// File: tb/tb_row_scan_controller.sv
// tb/tb_row_scan_controller.sv - directed table-driven bench for row_scan_controller (DWELL=1 and DWELL=3)
module tb_row_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        row_ready;
  logic [15:0] pattern;
  int          sel;

  logic        cr1, sc1, rv1, bz1;
  logic [15:0] rd1;
  logic        cr3, sc3, rv3, bz3;
  logic [15:0] rd3;
  logic [3:0]  cnt1, cnt3;
  logic        cell1, cell3;

  logic        cr, sc, rv, bz;
  logic [15:0] rd;
  logic [3:0]  cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign cell1 = pattern[cnt1];
  assign cell3 = pattern[cnt3];

  row_scan_controller #(.DWELL(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_cell_in(cell1),
    .o_count_reset(cr1), .o_scan(sc1), .o_row_data(rd1), .o_row_valid(rv1),
    .i_row_ready(row_ready), .o_busy(bz1)
  );

  row_scan_controller #(.DWELL(3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_cell_in(cell3),
    .o_count_reset(cr3), .o_scan(sc3), .o_row_data(rd3), .o_row_valid(rv3),
    .i_row_ready(row_ready), .o_busy(bz3)
  );

  // Behavioural model of the external 4-bit index counter
  always @(posedge clk) begin
    if (reset || cr1) cnt1 <= 4'd0;
    else if (sc1)     cnt1 <= cnt1 + 4'd1;
    if (reset || cr3) cnt3 <= 4'd0;
    else if (sc3)     cnt3 <= cnt3 + 4'd1;
  end

  always_comb begin
    cr = cr1; sc = sc1; rv = rv1; bz = bz1; rd = rd1; cnt = cnt1;
    if (sel == 1) begin
      cr = cr3; sc = sc3; rv = rv3; bz = bz3; rd = rd3; cnt = cnt3;
    end
  end

  typedef struct {
    int          sel;
    int          dwell;
    logic [15:0] pat;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz1 || bz3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", int'(bz1 | bz3), 0);
  endtask

  task automatic run_row(input vec_t v);
    int k, lat, ncr, nsc, bad;
    logic exp_sc;
    wait_idle();
    sel = v.sel;
    @(negedge clk);
    pattern   = v.pat;
    start     = 1'b1;
    row_ready = 1'b1;
    k = 0; lat = -1; ncr = 0; nsc = 0; bad = 0;
    while (k < 400 && lat < 0) begin
      @(negedge clk);
      start = 1'b0;
      if (cr) ncr++;
      if (sc) nsc++;
      exp_sc = (k >= 1) && (k <= 16 * v.dwell) && (k % v.dwell == 0);
      if (sc != exp_sc) bad++;
      if (rv) lat = k;
      else    k++;
    end
    chk("latency", lat, v.exp_lat);
    chk("row_data", int'(rd), int'(v.exp_data));
    chk("count_reset_cycles", ncr, 1);
    chk("scan_cycles", nsc, 16);
    chk("scan_timing_errs", bad, 0);
    chk("busy_in_done", int'(bz), 1);
    @(negedge clk);
    chk("valid_after_accept", int'(rv), 0);
    chk("busy_after_accept", int'(bz), 0);
    chk("counter_at_rest", int'(cnt), 0);
    chk("row_data_held", int'(rd), int'(v.exp_data));
  endtask

  initial begin
    int errs, n, t, r, prev_t;
    logic seen;
    logic [15:0] held;
    logic [15:0] pats[4];

    vecs[0] = '{0, 1, 16'hA5C3, 16'hA5C3, 17};
    vecs[1] = '{1, 3, 16'h8001, 16'h8001, 49};
    vecs[2] = '{0, 1, 16'h0000, 16'h0000, 17};
    vecs[3] = '{0, 1, 16'h5A5A, 16'h5A5A, 17};
    vecs[4] = '{1, 3, 16'h7FFE, 16'h7FFE, 49};

    reset = 1'b1; start = 1'b0; row_ready = 1'b0; pattern = 16'h0000; sel = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and quiet idle
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cr1 || sc1 || rv1 || bz1 || cr3 || sc3 || rv3 || bz3) errs++;
      if (rd1 != 16'h0000 || rd3 != 16'h0000) errs++;
    end
    chk("idle_outputs_nonzero", errs, 0);

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // Consumer stalls in DONE; start pulses there and together with row_ready are ignored
    wait_idle();
    sel = 0;
    @(negedge clk);
    pattern = 16'h3C96; start = 1'b1; row_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!rv1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_reached", int'(rv1), 1);
    held = rd1;
    chk("hold_row_data", int'(held), 16'h3C96);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (!rv1 || !bz1 || sc1 || cr1 || rd1 != held) errs++;
    end
    chk("hold_stability_errs", errs, 0);
    start = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_busy_after_accept", int'(bz1), 0);
    chk("hold_valid_after_accept", int'(rv1), 0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cr1 || bz1 || sc1) errs++;
    end
    chk("no_second_scan_errs", errs, 0);

    // Reset in the middle of a scan at idx 7
    wait_idle();
    sel = 0;
    @(negedge clk);
    pattern = 16'h1234; start = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; seen = 1'b0;
    while (cnt1 != 4'd7 && n < 100) begin
      @(negedge clk);
      if (rv1) seen = 1'b1;
      n++;
    end
    chk("reached_idx7", int'(cnt1), 7);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(bz1), 0);
    chk("rst_scan_strobes", int'({cr1, sc1}), 0);
    chk("rst_row_data", int'(rd1), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv1 || bz1) seen = 1'b1;
    end
    chk("aborted_row_presented", int'(seen), 0);
    run_row('{0, 1, 16'hFFFF, 16'hFFFF, 17});

    // Back-to-back rows, start held high, consumer always ready
    wait_idle();
    sel = 0;
    pats[0] = 16'h0F0F; pats[1] = 16'hC3A5; pats[2] = 16'h1001; pats[3] = 16'h0000;
    @(negedge clk);
    pattern = pats[0]; start = 1'b1; row_ready = 1'b1;
    t = 0; r = 0; prev_t = -1;
    while (r < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (rv1) begin
        chk("b2b_row_data", int'(rd1), int'(pats[r]));
        if (prev_t >= 0) chk("b2b_period", t - prev_t, 19);
        prev_t = t;
        r++;
        pattern = pats[r];
      end
    end
    chk("b2b_rows_done", r, 3);
    start = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
